rv32_mem_access_unit: RTL and testbench
=======================================

// Module: rv32_mem_access_unit
// PURPOSE
//  Consumer side of the EX->MEM pipeline register. Takes the registered EX/MEM outputs and runs one
//  data-memory transaction per load/store over a req/ack bus. Formats load data for WB and generates
//  byte enables for stores. Stalls the pipeline (IF..EX/MEM) while a transaction is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max REQ cycles without dmem_ack before bus_err; 1..65535; counter is 16 bits
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   reset, asynchronous, active-low
//  alu_res_in     in   32  effective address (EX/MEM alu_res_out)
//  data_store_in  in   32  store data (EX/MEM data_store_out)
//  data_ctrl_in   in   2   2'b10 = load; 2'b11 = store; 2'b0x = no access (EX/MEM reset value 2'b01 = none)
//  code_in        in   32  current instruction; funct3 = code_in[14:12] selects width/sign
//  pc_hlt_in      in   1   1 = halted/bubble; suppresses any access
//  dmem_req       out  1   request valid; held high until dmem_ack
//  dmem_we        out  1   1 = write
//  dmem_addr      out  32  word-aligned address {alu_res_in[31:2],2'b00}
//  dmem_be        out  4   byte enables
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_rdata     in   32  read data; valid in the cycle dmem_ack=1
//  dmem_ack       in   1   transaction complete (single-cycle pulse)
//  load_data_out  out  32  formatted load result; valid in DONE
//  mem_stall      out  1   1 = freeze upstream pipeline and EX/MEM register
//  align_err      out  1   1-cycle pulse: misaligned access or illegal funct3
//  bus_err        out  1   1-cycle pulse (in DONE): timeout, no ack
// BEHAVIOUR
//  access = data_ctrl_in[1] & ~pc_hlt_in. FSM states: IDLE, REQ, DONE.
//  IDLE: access & aligned & legal funct3 -> REQ; mem_stall = 1 combinationally in that cycle.
//   Misaligned or illegal -> stay IDLE, align_err = 1 for that cycle, no stall, no request.
//   Alignment: H (funct3 x01) needs addr[0]=0; W (010) needs addr[1:0]=0.
//   Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
//  REQ: dmem_req = 1, mem_stall = 1, with addr/we/be/wdata from current inputs (EX/MEM frozen, so stable).
//   On dmem_ack: capture formatted rdata -> DONE.
//   On timeout_cnt == TIMEOUT_CYCLES-1 without ack: data 0 -> DONE, bus_err = 1 in DONE.
//  DONE: one cycle, mem_stall = 0, load_data_out valid; the pipeline advances at this edge -> IDLE.
//  Min latency: ack in the 1st REQ cycle gives 2 stall cycles; load data is available in the 3rd cycle (DONE).
//  timeout_cnt: cleared on entry to REQ; increments each REQ cycle without ack; saturates; width 16 bits.
//  Store be/wdata: SB be = 4'b0001 << addr[1:0], wdata = {4{d[7:0]}};
//   SH be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{d[15:0]}}; SW be = 4'b1111, wdata = d.
//  Load be = 4'b1111 and dmem_wdata = 0 for loads.
//  Load format: select byte/half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//  Stores write load_data_out = 0.
//  Outside REQ: dmem_req = 0, dmem_we = 0, dmem_be = 0, dmem_addr = 0, dmem_wdata = 0.
//  load_data_out is registered and holds its value until the next DONE.
//  A late ack (arriving after a timeout, in DONE/IDLE) is ignored.
//  Reset (async, any state): state = IDLE, timeout_cnt = 0, load_data_out = 0.
//   All dmem_* outputs = 0, mem_stall = 0 (until inputs present an access), align_err = 0, bus_err = 0.
//   Reset mid-REQ drops dmem_req immediately; the memory must tolerate an abandoned request.
//  Reset value of EX/MEM (data_ctrl 2'b01, pc_hlt 1) produces no access.
// TESTING
//  1 LW addr 0x100, ack in 1st REQ cycle, rdata 0xDEADBEEF
//    -> stall 2 cycles, req 1 cycle, be 4'hF, DONE load_data 0xDEADBEEF.
//  2 LB addr 0x103, rdata 0x80112233 -> load_data 0xFFFFFF80.
//    LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
//  3 SH addr 0x206, data 0x1234ABCD -> we=1, be 4'b1100, wdata 0xABCDABCD, addr 0x204; load_data 0.
//  4 LW addr 0x101 -> align_err pulse, dmem_req never asserts, mem_stall 0.
//    data_ctrl 2'b10 with pc_hlt 1 -> nothing.
//  5 TIMEOUT_CYCLES=4, no ack -> req high exactly 4 cycles, then DONE with bus_err=1, load_data 0, back to IDLE.
//  6 rst_n low during REQ -> dmem_req, mem_stall drop asynchronously; after release with data_ctrl 2'b01 stays IDLE.

Source files
------------

// File: rtl/rv32_mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The master side issues one request at a time and holds it until it is acknowledged.
interface rv32_mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/rv32_mem_access_unit.sv
// MEM stage: one data-memory transaction per load/store, with load formatting,
// store lane steering, pipeline stall and a request timeout.
module rv32_mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   alu_res_in,
    input  logic [31:0]                   data_store_in,
    input  logic [1:0]                    data_ctrl_in,
    input  logic [31:0]                   code_in,
    input  logic                          pc_hlt_in,
    rv32_mem_access_unit_if.master        dmem,
    output logic [31:0]                   load_data_out,
    output logic                          mem_stall,
    output logic                          align_err,
    output logic                          bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [15:0] TLAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic        bus_err_q, bus_err_d;

    logic [2:0]  f3;
    logic [1:0]  a;
    logic        access, is_store, legal, aligned, ok;
    logic [31:0] shifted, fmt, st_wdata;
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [3:0]  st_be;
    logic        unused_ok;

    assign unused_ok = ^{code_in[31:15], code_in[11:0]};

    always_comb begin
        f3       = code_in[14:12];
        a        = alu_res_in[1:0];
        is_store = data_ctrl_in[0];
        access   = data_ctrl_in[1] & ~pc_hlt_in;
        legal    = is_store ? (f3 inside {3'b000, 3'b001, 3'b010})
                            : (f3 inside {3'b000, 3'b001, 3'b010,
                                          3'b100, 3'b101});
        aligned  = 1'b1;
        if (f3[1:0] == 2'b01)      aligned = ~a[0];
        else if (f3[1:0] == 2'b10) aligned = (a == 2'b00);
        ok       = legal & aligned;

        shifted  = dmem.rdata >> {a, 3'b000};
        byte_v   = shifted[7:0];
        half     = a[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        unique case (f3)
            3'b000:  fmt = {{24{byte_v[7]}}, byte_v};
            3'b001:  fmt = {{16{half[15]}}, half};
            3'b010:  fmt = dmem.rdata;
            3'b100:  fmt = {24'd0, byte_v};
            3'b101:  fmt = {16'd0, half};
            default: fmt = 32'd0;
        endcase

        unique case (f3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << a;
                st_wdata = {4{data_store_in[7:0]}};
            end
            2'b01: begin
                st_be    = a[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{data_store_in[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = data_store_in;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tcnt_q      <= 16'd0;
            load_data_q <= 32'd0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            load_data_q <= load_data_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        load_data_d = load_data_q;
        bus_err_d   = 1'b0;
        mem_stall   = 1'b0;
        align_err   = 1'b0;
        dmem.req    = 1'b0;
        dmem.we     = 1'b0;
        dmem.addr   = 32'd0;
        dmem.be     = 4'd0;
        dmem.wdata  = 32'd0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (ok) begin
                        state_d   = REQ;
                        tcnt_d    = 16'd0;
                        mem_stall = 1'b1;
                    end else begin
                        align_err = 1'b1;
                    end
                end
            end
            REQ: begin
                mem_stall  = 1'b1;
                dmem.req   = 1'b1;
                dmem.we    = is_store;
                dmem.addr  = {alu_res_in[31:2], 2'b00};
                dmem.be    = is_store ? st_be : 4'b1111;
                dmem.wdata = is_store ? st_wdata : 32'd0;
                if (dmem.ack) begin
                    state_d     = DONE;
                    load_data_d = is_store ? 32'd0 : fmt;
                end else if (tcnt_q == TLAST) begin
                    state_d     = DONE;
                    load_data_d = 32'd0;
                    bus_err_d   = 1'b1;
                end else if (tcnt_q != 16'hFFFF) begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign load_data_out = load_data_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_rv32_mem_access_unit.sv
// Scoreboard bench for rv32_mem_access_unit: directed loads/stores against a
// small acking memory responder; a negedge monitor checks each completed access.
module tb_rv32_mem_access_unit;

    typedef struct packed {
        logic [31:0] data;
        logic        bus;
        logic [7:0]  nst;
        logic [7:0]  nrq;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_res_in, data_store_in, code_in;
    logic [1:0]  data_ctrl_in;
    logic        pc_hlt_in;
    logic [31:0] load_data_out;
    logic        mem_stall, align_err, bus_err;

    rv32_mem_access_unit_if dmem ();

    rv32_mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_res_in    (alu_res_in),
        .data_store_in (data_store_in),
        .data_ctrl_in  (data_ctrl_in),
        .code_in       (code_in),
        .pc_hlt_in     (pc_hlt_in),
        .dmem          (dmem.master),
        .load_data_out (load_data_out),
        .mem_stall     (mem_stall),
        .align_err     (align_err),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    int   passes = 0;
    int   checks = 0;
    exp_t q[$];

    int          ack_delay = 0;
    logic [31:0] mem_rdata = 32'd0;
    int          req_seen  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // memory responder
    initial begin
        dmem.ack   = 1'b0;
        dmem.rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n && dmem.req) begin
                if (ack_delay >= 0 && req_seen == ack_delay) begin
                    dmem.ack   = 1'b1;
                    dmem.rdata = mem_rdata;
                end else begin
                    dmem.ack = 1'b0;
                end
                req_seen++;
            end else begin
                dmem.ack = 1'b0;
                req_seen = 0;
            end
        end
    end

    // monitor / scoreboard
    logic        prev_stall = 1'b0;
    int          nst = 0, nrq = 0;
    logic        c_we;
    logic [3:0]  c_be;
    logic [31:0] c_wdata, c_addr;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                nst = 0;
                nrq = 0;
            end else begin
                if (mem_stall) nst++;
                if (dmem.req) begin
                    nrq++;
                    c_we    = dmem.we;
                    c_be    = dmem.be;
                    c_wdata = dmem.wdata;
                    c_addr  = dmem.addr;
                end
                if (prev_stall && !mem_stall) begin
                    if (q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_done: got 1 expected 0");
                    end else begin
                        e = q.pop_front();
                        check("load_data", load_data_out, e.data);
                        check("bus_err", {31'd0, bus_err}, {31'd0, e.bus});
                        check("stall_cycles", nst, {24'd0, e.nst});
                        check("req_cycles", nrq, {24'd0, e.nrq});
                        check("we", {31'd0, c_we}, {31'd0, e.we});
                        check("be", {28'd0, c_be}, {28'd0, e.be});
                        check("wdata", c_wdata, e.wdata);
                        check("addr", c_addr, e.addr);
                    end
                    nst = 0;
                    nrq = 0;
                end
                prev_stall = mem_stall;
            end
        end
    end

    task automatic bubble();
        data_ctrl_in  = 2'b01;
        pc_hlt_in     = 1'b1;
        alu_res_in    = 32'd0;
        data_store_in = 32'd0;
        code_in       = 32'd0;
    endtask

    task automatic do_txn(input logic [1:0] ctrl, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int delay,
                          input exp_t e);
        bit done = 0;
        @(posedge clk); #1;
        q.push_back(e);
        ack_delay     = delay;
        mem_rdata     = rdata;
        data_ctrl_in  = ctrl;
        pc_hlt_in     = 1'b0;
        alu_res_in    = addr;
        data_store_in = sdata;
        code_in       = {17'd0, f3, 12'h003};
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (!mem_stall) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            $display("FAIL txn_wait: got stalled expected done");
        end
        bubble();
    endtask

    task automatic no_access(input string name, input logic [1:0] ctrl,
                             input logic hlt, input logic [2:0] f3,
                             input logic [31:0] addr, input logic exp_al);
        bit seen_req = 0;
        @(posedge clk); #1;
        data_ctrl_in = ctrl;
        pc_hlt_in    = hlt;
        alu_res_in   = addr;
        code_in      = {17'd0, f3, 12'h003};
        #1;
        check({name, "_align"}, {31'd0, align_err}, {31'd0, exp_al});
        check({name, "_stall"}, {31'd0, mem_stall}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            if (dmem.req) seen_req = 1;
        end
        check({name, "_req"}, {31'd0, seen_req}, 32'd0);
        bubble();
    endtask

    initial begin
        rst_n = 1'b0;
        bubble();
        #22;
        check("rst_req", {31'd0, dmem.req}, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_load", load_data_out, 32'd0);
        check("rst_align", {31'd0, align_err}, 32'd0);
        check("rst_bus", {31'd0, bus_err}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        do_txn(2'b10, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0,
               '{32'hDEADBEEF, 1'b0, 8'd2, 8'd1, 1'b0, 4'hF, 32'd0, 32'h100});
        do_txn(2'b10, 3'b000, 32'h103, 0, 32'h80112233, 0,
               '{32'hFFFFFF80, 1'b0, 8'd2, 8'd1, 1'b0, 4'hF, 32'd0, 32'h100});
        do_txn(2'b10, 3'b100, 32'h103, 0, 32'h80112233, 0,
               '{32'h00000080, 1'b0, 8'd2, 8'd1, 1'b0, 4'hF, 32'd0, 32'h100});
        do_txn(2'b10, 3'b101, 32'h102, 0, 32'h80112233, 0,
               '{32'h00008011, 1'b0, 8'd2, 8'd1, 1'b0, 4'hF, 32'd0, 32'h100});
        do_txn(2'b10, 3'b001, 32'h102, 0, 32'h80112233, 0,
               '{32'hFFFF8011, 1'b0, 8'd2, 8'd1, 1'b0, 4'hF, 32'd0, 32'h100});
        do_txn(2'b10, 3'b010, 32'h108, 0, 32'hCAFEF00D, 2,
               '{32'hCAFEF00D, 1'b0, 8'd4, 8'd3, 1'b0, 4'hF, 32'd0, 32'h108});
        do_txn(2'b10, 3'b010, 32'h300, 0, 32'h11111111, -1,
               '{32'h0, 1'b1, 8'd5, 8'd4, 1'b0, 4'hF, 32'd0, 32'h300});
        do_txn(2'b11, 3'b001, 32'h206, 32'h1234ABCD, 32'h55555555, 0,
               '{32'h0, 1'b0, 8'd2, 8'd1, 1'b1, 4'b1100, 32'hABCDABCD, 32'h204});
        do_txn(2'b11, 3'b000, 32'h201, 32'h000000EF, 32'h0, 0,
               '{32'h0, 1'b0, 8'd2, 8'd1, 1'b1, 4'b0010, 32'hEFEFEFEF, 32'h200});
        do_txn(2'b11, 3'b010, 32'h208, 32'h01234567, 32'h0, 0,
               '{32'h0, 1'b0, 8'd2, 8'd1, 1'b1, 4'b1111, 32'h01234567, 32'h208});

        no_access("misaligned_lw", 2'b10, 1'b0, 3'b010, 32'h101, 1'b1);
        no_access("misaligned_sh", 2'b11, 1'b0, 3'b001, 32'h203, 1'b1);
        no_access("illegal_load", 2'b10, 1'b0, 3'b011, 32'h100, 1'b1);
        no_access("illegal_store", 2'b11, 1'b0, 3'b100, 32'h100, 1'b1);
        no_access("halted", 2'b10, 1'b1, 3'b010, 32'h100, 1'b0);

        do_txn(2'b10, 3'b010, 32'h104, 0, 32'h13579BDF, 0,
               '{32'h13579BDF, 1'b0, 8'd2, 8'd1, 1'b0, 4'hF, 32'd0, 32'h104});

        // abandon a request with reset
        @(posedge clk); #1;
        ack_delay    = -1;
        data_ctrl_in = 2'b10;
        pc_hlt_in    = 1'b0;
        alu_res_in   = 32'h100;
        code_in      = 32'h00002003;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pre_req", {31'd0, dmem.req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req", {31'd0, dmem.req}, 32'd0);
        check("rst_mid_load", load_data_out, 32'd0);
        bubble();
        #1;
        check("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_req", {31'd0, dmem.req}, 32'd0);
        check("post_rst_stall", {31'd0, mem_stall}, 32'd0);
        check("scoreboard_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
